change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Coin-return side of the vending machine: accepts a change-owed amount and drives a two-tube coin hopper (₹2 and ₹1) one coin at a time, using a command/acknowledge handshake.
- Tracks the coin count in each tube.
- Pays greedily, ₹2 coins first.
- Reports completion, any unpaid shortfall, and hopper faults back to the vending controller.

Parameters:
- AMT_W, 4, width of change amount in rupees.
- CNT_W, 6, width of each tube inventory counter.
- INIT_TWO, 8, ₹2 tube count after reset or refill.
- INIT_ONE, 8, ₹1 tube count after reset or refill.
- TIMEOUT, 16, maximum cycles an eject command may wait for ack (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  change request strobe, sampled only while req_ready=1.
- req_amount  in  AMT_W  rupees owed, captured with req_valid.
- req_ready  out  1  high only in IDLE.
- refill  in  1  reload both tube counts to their INIT values; honoured only in IDLE.
- eject_2  out  1  command: eject one ₹2 coin; held until ack.
- eject_1  out  1  command: eject one ₹1 coin; held until ack.
- eject_ack  in  1  hopper confirms the commanded coin has left.
- done  out  1  one-cycle completion pulse.
- short  out  1  valid with done; 1 if amount was not fully paid.
- shortfall  out  AMT_W  valid with done; unpaid rupees.
- fault  out  1  sticky; set on ack timeout, cleared only by reset.
- cnt_two  out  CNT_W  current ₹2 tube count.
- cnt_one  out  CNT_W  current ₹1 tube count.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All command and status outputs go to 0, including eject_2, eject_1, done, short, shortfall and fault.
  - cnt_two=INIT_TWO, cnt_one=INIT_ONE.
  - Remaining-amount register is cleared.
  - Any reset mid-operation aborts immediately, with no done pulse.
- Outputs are Moore decodes of registered state and registers:
  - eject_2 = (state==EJ2), eject_1 = (state==EJ1).
  - done = (state==DONE), req_ready = (state==IDLE).
  - The two eject outputs are never high together.
- IDLE:
  - If refill=1: both counts reload at the clock edge.
  - If req_valid=1: remaining <= req_amount, go to SEL.
  - If both are high in the same cycle, both take effect, and SEL uses the reloaded counts.
- SEL (one cycle), checked in priority order:
  1. remaining==0 → DONE.
  2. Else remaining≥2 and cnt_two>0 → EJ2.
  3. Else remaining≥1 and cnt_one>0 → EJ1. This includes the case remaining≥2 with the ₹2 tube empty.
  4. Else → DONE.
- EJ2 / EJ1:
  - A timeout counter is cleared on entry.
  - eject_ack is sampled at each edge. Ack in the first cycle the command is high is valid.
  - On ack in EJ2: remaining -= 2, cnt_two -= 1, go to SEL.
  - On ack in EJ1: remaining -= 1, cnt_one -= 1, go to SEL.
  - This gives one idle cycle (command low) between successive coins.
  - If TIMEOUT cycles elapse without ack: fault <= 1, counts unchanged, go to DONE.
- DONE (one cycle):
  - done=1, shortfall=remaining, short=(remaining!=0).
  - Next state IDLE.
  - short and shortfall return to 0 when leaving DONE.
- Latency:
  - Request accepted at edge N; the first eject is high in cycle N+2.
  - req_amount=0 gives done high in cycle N+2 with no eject.
- Ignored inputs:
  - eject_ack outside EJ states.
  - req_valid and refill outside IDLE.
- Counters never underflow, because SEL checks for a nonzero count before ejecting.
- Requests are still serviced after fault is set; fault is status only.

Test Plan:
1. Reset, req_amount=5, ack one cycle after each command → eject_2, eject_2, eject_1 in order; done with short=0, shortfall=0; cnt_two=6, cnt_one=7; req_ready=1 the cycle after done.
2. Drain the ₹2 tube to cnt_two=0, then request 3 → three eject_1 pulses only; short=0; cnt_one reduced by 3.
3. Set inventory to cnt_two=1, cnt_one=1 (via prior requests), then request 5 → eject_2, then eject_1; done with short=1, shortfall=2; both counts 0.
4. Request 0 → no eject asserted; done pulses exactly 2 cycles after acceptance with short=0. Also: refill and req_valid in the same cycle after the tubes are drained → counts reload and the request is paid in full.
5. TIMEOUT=16, request 2, eject_ack held low → eject_2 high for 16 cycles then drops; done with short=1, shortfall=2; fault=1 and stays high through later successful requests.
6. Assert rst_n=0 mid-EJ1 → eject_1 drops asynchronously; no done pulse; counts back to INIT_TWO/INIT_ONE; fault=0; req_ready=1 after release.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: pays a rupee amount greedily from a two-tube hopper (Rs2 then Rs1)
// using a per-coin eject/ack handshake, tracking tube inventory and ack timeouts.
module change_dispenser #(
    parameter int unsigned AMT_W    = 4,
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned INIT_TWO = 8,
    parameter int unsigned INIT_ONE = 8,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             refill,
    output logic             eject_2,
    output logic             eject_1,
    input  logic             eject_ack,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] shortfall,
    output logic             fault,
    output logic [CNT_W-1:0] cnt_two,
    output logic [CNT_W-1:0] cnt_one
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_EJ2  = 3'd2,
        S_EJ1  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [AMT_W-1:0] remaining, remaining_nxt;
    logic [CNT_W-1:0] two_q, two_nxt;
    logic [CNT_W-1:0] one_q, one_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic             fault_q, fault_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers: amount still owed, tube inventory, ack timer, sticky fault
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            two_q     <= CNT_W'(INIT_TWO);
            one_q     <= CNT_W'(INIT_ONE);
            timer     <= '0;
            fault_q   <= 1'b0;
        end else begin
            remaining <= remaining_nxt;
            two_q     <= two_nxt;
            one_q     <= one_nxt;
            timer     <= timer_nxt;
            fault_q   <= fault_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        two_nxt       = two_q;
        one_nxt       = one_q;
        timer_nxt     = timer;
        fault_nxt     = fault_q;

        case (state)
            S_IDLE: begin
                if (refill) begin
                    two_nxt = CNT_W'(INIT_TWO);
                    one_nxt = CNT_W'(INIT_ONE);
                end
                if (req_valid) begin
                    remaining_nxt = req_amount;
                    state_nxt     = S_SEL;
                end
            end
            S_SEL: begin
                timer_nxt = '0;
                // Greedy pick; nonzero-count checks keep the tubes from underflowing
                if (remaining == '0) begin
                    state_nxt = S_DONE;
                end else if (remaining >= AMT_W'(2) && two_q != '0) begin
                    state_nxt = S_EJ2;
                end else if (one_q != '0) begin
                    state_nxt = S_EJ1;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_EJ2, S_EJ1: begin
                if (eject_ack) begin
                    if (state == S_EJ2) begin
                        remaining_nxt = remaining - AMT_W'(2);
                        two_nxt       = two_q - CNT_W'(1);
                    end else begin
                        remaining_nxt = remaining - AMT_W'(1);
                        one_nxt       = one_q - CNT_W'(1);
                    end
                    state_nxt = S_SEL;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    fault_nxt = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore decodes of registered state
    assign req_ready = (state == S_IDLE);
    assign eject_2   = (state == S_EJ2);
    assign eject_1   = (state == S_EJ1);
    assign done      = (state == S_DONE);
    assign short     = (state == S_DONE) && (remaining != '0);
    assign shortfall = (state == S_DONE) ? remaining : '0;
    assign fault     = fault_q;
    assign cnt_two   = two_q;
    assign cnt_one   = one_q;

endmodule
